// File: rtl/countdown_timer_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_if
//
// Purpose : Control/status bundle between a countdown_timer and the logic that
//           drives it (software-facing register block or a controlling FSM).
//
// Parameters:
//   NUMBITS    width of load_value and count
//
// Signals:
//   start       controller -> timer  load load_value and begin counting
//   load_value  controller -> timer  number of cycles to count
//   pause       controller -> timer  level, freezes the count while high
//   stop        controller -> timer  abort, return to idle without done
//   count       timer -> controller  current remaining count
//   busy        timer -> controller  high while running or held
//   done        timer -> controller  one-cycle pulse on terminal count
//
// Modports:
//   master  the controlling side (drives start/load_value/pause/stop)
//   slave   the timer itself
// -----------------------------------------------------------------------------
interface countdown_timer_if #(
  parameter int NUMBITS = 8
);
  logic               start;
  logic [NUMBITS-1:0] load_value;
  logic               pause;
  logic               stop;
  logic [NUMBITS-1:0] count;
  logic               busy;
  logic               done;

  modport master (
    output start, load_value, pause, stop,
    input  count, busy, done
  );

  modport slave (
    input  start, load_value, pause, stop,
    output count, busy, done
  );
endinterface : countdown_timer_if

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Purpose : Loadable down-counter used for programmable delays and timeouts.
//           A start in IDLE loads a cycle count; the block decrements once per
//           unpaused cycle and emits a one-cycle registered done pulse when the
//           count reaches zero. Paused cycles do not count. A stop aborts the
//           run without a done pulse.
//
// Parameters:
//   NUMBITS    width of the counter and of load_value (default 8)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   bus        countdown_timer_if.slave
//                start/load_value/pause/stop in, count/busy/done out
//
// Configuration macro:
//   COUNTDOWN_AUTORELOAD_EN
//     undefined : one-shot, the terminal decrement returns to IDLE
//     defined   : the terminal decrement reloads the last loaded value and
//                 keeps running, so done repeats every V unpaused cycles
//                 until stop or reset. start with V=0 stays one-shot.
//
// Edge priority: reset > stop > start > pause. stop and pause are meaningless
// in IDLE; start is ignored outside IDLE.
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int NUMBITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  countdown_timer_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [NUMBITS-1:0] W_ZERO = '0;
  localparam logic [NUMBITS-1:0] W_ONE  = NUMBITS'(1);

  state_t             r_state;
  logic [NUMBITS-1:0] r_count;
  logic [NUMBITS-1:0] r_reload;
  logic               r_busy;
  logic               r_done;

  // Terminal decrement is detected one step early so count never wraps.
  logic w_terminal;
  assign w_terminal = (r_count == W_ONE);

  // Single-process FSM: state and every output are registered together, so
  // busy always agrees with the state it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state  <= S_IDLE;
      r_count  <= W_ZERO;
      r_reload <= W_ZERO;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // done is a pulse: it is only raised by the branches below for one edge.
      r_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          // stop and pause are ignored here, so start wins even with stop high.
          if (bus.start) begin
            if (bus.load_value != W_ZERO) begin
              r_count  <= bus.load_value;
              r_reload <= bus.load_value;
              r_busy   <= 1'b1;
              r_state  <= S_RUN;
            end else begin
              // Zero-length delay: report completion immediately, never busy.
              r_done <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (bus.stop) begin
            r_count <= W_ZERO;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (bus.pause) begin
            // Pause outranks the terminal decrement: a paused count of 1 waits.
            r_state <= S_HOLD;
          end else if (w_terminal) begin
            r_done <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            r_count <= r_reload;
`else
            r_count <= W_ZERO;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
`endif
          end else begin
            r_count <= r_count - W_ONE;
          end
        end

        S_HOLD: begin
          if (bus.stop) begin
            r_count <= W_ZERO;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!bus.pause) begin
            // The exit edge itself does not decrement; counting resumes on the
            // following edge, which costs one extra cycle per HOLD->RUN exit.
            r_state <= S_RUN;
          end
        end

        default: begin
          r_count <= W_ZERO;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.count = r_count;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Table-driven bench for countdown_timer. Each table row is one clock edge:
// the row's inputs are applied before the edge and count/busy/done are
// compared 1 ns after it. The table is built for the one-shot build by
// default, and for the auto-reload build when COUNTDOWN_AUTORELOAD_EN is
// defined. A hand-written sequence afterwards measures start-to-done latency
// with a bounded wait.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int NUMBITS = 8;

  logic clk;
  logic reset;

  countdown_timer_if #(.NUMBITS(NUMBITS)) bus ();

  countdown_timer #(.NUMBITS(NUMBITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic               rst;
    logic               start;
    logic [NUMBITS-1:0] load_value;
    logic               pause;
    logic               stop;
    logic [NUMBITS-1:0] exp_count;
    logic               exp_busy;
    logic               exp_done;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic add(input string name, input logic rst, input logic st,
                     input int lv, input logic pa, input logic sp,
                     input int ec, input logic eb, input logic ed);
    vec_t v;
    v.name       = name;
    v.rst        = rst;
    v.start      = st;
    v.load_value = NUMBITS'(lv);
    v.pause      = pa;
    v.stop       = sp;
    v.exp_count  = NUMBITS'(ec);
    v.exp_busy   = eb;
    v.exp_done   = ed;
    vecs.push_back(v);
  endtask

  // Idle-input row: nothing asserted, just let one edge pass.
  task automatic tick(input string name, input int ec, input logic eb,
                      input logic ed);
    add(name, 1'b0, 1'b0, 0, 1'b0, 1'b0, ec, eb, ed);
  endtask

  task automatic drive(input logic rst, input logic st, input logic [NUMBITS-1:0] lv,
                       input logic pa, input logic sp);
    reset          = rst;
    bus.start      = st;
    bus.load_value = lv;
    bus.pause      = pa;
    bus.stop       = sp;
  endtask

  task automatic build_table();
    add("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
    add("reset1", 1, 0, 0, 0, 0, 0, 0, 0);
`ifndef COUNTDOWN_AUTORELOAD_EN
    // V=5 plain run: 5,4,3,2,1,0 with done 5 edges after start.
    add("v5_start", 0, 1, 5, 0, 0, 5, 1, 0);
    tick("v5_4", 4, 1, 0);
    tick("v5_3", 3, 1, 0);
    tick("v5_2", 2, 1, 0);
    tick("v5_1", 1, 1, 0);
    tick("v5_done", 0, 0, 1);
    tick("v5_after", 0, 0, 0);
    // V=6 with three paused cycles once count=4: done 10 edges after start.
    add("v6_start", 0, 1, 6, 0, 0, 6, 1, 0);
    tick("v6_5", 5, 1, 0);
    tick("v6_4", 4, 1, 0);
    add("v6_p1", 0, 0, 0, 1, 0, 4, 1, 0);
    add("v6_p2", 0, 0, 0, 1, 0, 4, 1, 0);
    add("v6_p3", 0, 0, 0, 1, 0, 4, 1, 0);
    tick("v6_exit", 4, 1, 0);
    tick("v6_3", 3, 1, 0);
    tick("v6_2", 2, 1, 0);
    tick("v6_1", 1, 1, 0);
    tick("v6_done", 0, 0, 1);
    tick("v6_after", 0, 0, 0);
    // V=8 stopped at count=3, then V=2 completes normally.
    add("v8_start", 0, 1, 8, 0, 0, 8, 1, 0);
    tick("v8_7", 7, 1, 0);
    tick("v8_6", 6, 1, 0);
    tick("v8_5", 5, 1, 0);
    tick("v8_4", 4, 1, 0);
    tick("v8_3", 3, 1, 0);
    add("v8_stop", 0, 0, 0, 0, 1, 0, 0, 0);
    tick("v8_nodone", 0, 0, 0);
    add("v2_start", 0, 1, 2, 0, 0, 2, 1, 0);
    tick("v2_1", 1, 1, 0);
    tick("v2_done", 0, 0, 1);
    tick("v2_after", 0, 0, 0);
    // V=0: done next edge, busy never rises.
    add("v0_start", 0, 1, 0, 0, 0, 0, 0, 1);
    tick("v0_after", 0, 0, 0);
    // start during RUN with another value is ignored.
    add("v3_start", 0, 1, 3, 0, 0, 3, 1, 0);
    add("v3_restart", 0, 1, 9, 0, 0, 2, 1, 0);
    tick("v3_1", 1, 1, 0);
    tick("v3_done", 0, 0, 1);
    // start in the cycle done is high is accepted (zero-gap back-to-back).
    add("b2b_start", 0, 1, 2, 0, 0, 2, 1, 0);
    tick("b2b_1", 1, 1, 0);
    tick("b2b_done", 0, 0, 1);
    // stop together with start in IDLE: start wins. V=1 finishes next edge.
    add("ss_start", 0, 1, 1, 0, 1, 1, 1, 0);
    tick("ss_done", 0, 0, 1);
    // pause and stop alone in IDLE do nothing.
    add("idle_pause", 0, 0, 0, 1, 0, 0, 0, 0);
    add("idle_stop", 0, 0, 0, 0, 1, 0, 0, 0);
    // Pause at count=1 holds off the terminal decrement.
    add("p1_start", 0, 1, 2, 0, 0, 2, 1, 0);
    tick("p1_1", 1, 1, 0);
    add("p1_hold", 0, 0, 0, 1, 0, 1, 1, 0);
    tick("p1_exit", 1, 1, 0);
    tick("p1_done", 0, 0, 1);
    // start ignored in HOLD, stop from HOLD clears without done.
    add("h_start", 0, 1, 4, 0, 0, 4, 1, 0);
    add("h_pause", 0, 0, 0, 1, 0, 4, 1, 0);
    add("h_restart", 0, 1, 7, 1, 0, 4, 1, 0);
    add("h_stop", 0, 0, 0, 1, 1, 0, 0, 0);
    tick("h_nodone", 0, 0, 0);
    // reset at count=2 of a V=4 run: all outputs zero, no done.
    add("r_start", 0, 1, 4, 0, 0, 4, 1, 0);
    tick("r_3", 3, 1, 0);
    tick("r_2", 2, 1, 0);
    add("r_reset", 1, 0, 0, 0, 0, 0, 0, 0);
    tick("r_nodone", 0, 0, 0);
    // Full-scale load value.
    add("max_start", 0, 1, 255, 0, 0, 255, 1, 0);
    tick("max_254", 254, 1, 0);
    add("max_stop", 0, 0, 0, 0, 1, 0, 0, 0);
`else
    // Auto-reload V=3: 3,2,1,3,2,1 with done on each reload edge.
    add("ar_start", 0, 1, 3, 0, 0, 3, 1, 0);
    tick("ar_2a", 2, 1, 0);
    tick("ar_1a", 1, 1, 0);
    tick("ar_reload1", 3, 1, 1);
    tick("ar_2b", 2, 1, 0);
    tick("ar_1b", 1, 1, 0);
    tick("ar_reload2", 3, 1, 1);
    add("ar_ignore_start", 0, 1, 9, 0, 0, 2, 1, 0);
    add("ar_stop", 0, 0, 0, 0, 1, 0, 0, 0);
    tick("ar_nodone", 0, 0, 0);
    // V=0 stays one-shot.
    add("ar_v0", 0, 1, 0, 0, 0, 0, 0, 1);
    tick("ar_v0_after", 0, 0, 0);
    // Pause at count=1 delays the reload.
    add("ar_p_start", 0, 1, 2, 0, 0, 2, 1, 0);
    tick("ar_p_1", 1, 1, 0);
    add("ar_p_hold", 0, 0, 0, 1, 0, 1, 1, 0);
    tick("ar_p_exit", 1, 1, 0);
    tick("ar_p_reload", 2, 1, 1);
    add("ar_p_reset", 1, 0, 0, 0, 0, 0, 0, 0);
    tick("ar_p_after", 0, 0, 0);
`endif
  endtask

  initial begin
    int latency;
    bit seen;

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    build_table();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].load_value, vecs[i].pause, vecs[i].stop);
      @(posedge clk);
      #1;
      check({vecs[i].name, ".count"}, 32'(bus.count), 32'(vecs[i].exp_count));
      check({vecs[i].name, ".busy"},  32'(bus.busy),  32'(vecs[i].exp_busy));
      check({vecs[i].name, ".done"},  32'(bus.done),  32'(vecs[i].exp_done));
    end

    // Longer run: done must arrive exactly 20 edges after the start edge.
    drive(1'b0, 1'b1, NUMBITS'(20), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    latency = 0;
    seen    = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen    = 1'b1;
        latency = c;
      end
    end
    check("lat20.seen", 32'(seen), 32'd1);
    check("lat20.edges", 32'(latency), 32'd20);

    // Abort whatever remains (auto-reload keeps running) and confirm idle.
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("final.busy", 32'(bus.busy), 32'd0);
    check("final.count", 32'(bus.count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with start/pause/stop control and a one-cycle terminal pulse. It is the count-down counterpart of the team's free-running up-counter. Control logic uses it for programmable delays and timeouts: software or an FSM loads a cycle count, and the block reports when that many cycles have elapsed. Paused cycles do not count.

## Interface
Parameters:
- NUMBITS, default 8: width of the counter and of `load_value`.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; sampled only on the rising edge of `clk`.
- start  input  1  load `load_value` and begin counting; acted on only in IDLE.
- load_value  input  NUMBITS  number of cycles to count; sampled with `start`.
- pause  input  1  level; freezes the count while high.
- stop  input  1  abort: return to IDLE, count cleared, no `done`.
- count  output  NUMBITS  current remaining count.
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle registered pulse on terminal count.

## Operation
- States:
  - IDLE: waiting; `count`=0.
  - RUN: decrementing.
  - HOLD: paused, `count` frozen.
- Priority at each edge: `reset` > `stop` > `start` > `pause`.
- IDLE:
  - `start`=1 with `load_value`≠0: `count`<=`load_value`, go to RUN, load `reload_reg`<=`load_value`.
  - `start`=1 with `load_value`=0: stay in IDLE, pulse `done` next cycle, `count` stays 0.
  - `pause` and `stop` have no effect.
- RUN:
  - `stop`: go to IDLE, `count`<=0, `done`=0.
  - `pause`: go to HOLD, `count` unchanged.
  - Otherwise `count`<=`count`-1.
  - When `count`==1 (terminal decrement): `count`<=0, `done`<=1, go to IDLE.
- HOLD:
  - `stop`: go to IDLE, `count`<=0.
  - `pause`=0: go to RUN. No decrement on the exit edge; decrementing resumes on the following edge.
- `start` in RUN or HOLD is ignored. No restart, no error flag.
- Arithmetic is unsigned, NUMBITS wide. `count` never underflows, because the terminal decrement is detected at `count`==1.
- `busy` = (state ≠ IDLE), registered together with the state.

## Timing
- Reset values: `count`=0, `busy`=0, `done`=0, state=IDLE, `reload_reg`=0.
- `reset` asserted mid-count: all outputs take their reset values after that edge. No `done` pulse is produced.
- Latency, `start` sampled at edge E with value V and no pause:
  - After E: `count`=V, `busy`=1.
  - After E+k: `count`=V-k.
  - After E+V: `count`=0, `busy`=0, `done`=1.
  - After E+V+1: `done`=0.
- Total latency from the `start` edge to the `done` edge is V cycles plus the number of cycles spent in HOLD plus the number of HOLD→RUN transitions.
- `done` is high for exactly one cycle per terminal event.
- `start` asserted in the same cycle that `done` is high: the block is in IDLE, so the new load is accepted. Back-to-back runs are allowed with zero gap.
- `stop` and `start` asserted together in IDLE: `stop` has no effect in IDLE, so `start` is accepted.

## Configuration
- Macro `COUNTDOWN_AUTORELOAD_EN`:
  - Undefined: one-shot behaviour exactly as described in Operation.
  - Defined: on the terminal decrement in RUN, `count`<=`reload_reg` instead of 0, the state stays RUN, `busy` stays 1, and `done` still pulses. `done` then repeats every V unpaused cycles until `stop` or `reset`.
  - Defined, `start` with V=0: same as one-shot. Single `done` pulse, stay in IDLE.

## Test plan
- Reset, then `start` with V=5 -> `count` reads 5,4,3,2,1,0; `busy` falls and `done`=1 for one cycle, 5 edges after the `start` edge.
- `start` V=6, `pause` high for 3 cycles after `count`=4 -> `count` holds 4 for the paused cycles plus 1; `done` arrives 10 edges after `start`.
- `start` V=8, `stop` at `count`=3 -> `count`=0, `busy`=0, no `done`. A later `start` V=2 completes normally.
- `start` V=0 -> `done` pulse next cycle, `busy` never asserted. `start` during RUN with a different value is ignored.
- `reset` asserted at `count`=2 of a V=4 run -> all outputs 0 at the next edge, no `done`.
- With `COUNTDOWN_AUTORELOAD_EN` defined, `start` V=3 -> `done` every 3 cycles and `count` sequence 3,2,1,3,2,1. `stop` ends it with `count`=0.
